// File: rtl/hilo_pkg.sv
// Shared op codes and op-class helpers for the HI/LO multiply/divide unit.
package hilo_pkg;

    // Default iteration count: one operand bit per cycle for 32-bit operands.
    localparam int HILO_ITER = 32;

    localparam logic [3:0] HILO_OP_MULT  = 4'd0;
    localparam logic [3:0] HILO_OP_MULTU = 4'd1;
    localparam logic [3:0] HILO_OP_MADD  = 4'd2;
    localparam logic [3:0] HILO_OP_MSUB  = 4'd3;
    localparam logic [3:0] HILO_OP_DIV   = 4'd4;
    localparam logic [3:0] HILO_OP_DIVU  = 4'd5;
    localparam logic [3:0] HILO_OP_MTHI  = 4'd6;
    localparam logic [3:0] HILO_OP_MTLO  = 4'd7;

    // Multiply family: MULT, MULTU, MADD, MSUB.
    function automatic logic is_mul(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

    // Divide family: DIV, DIVU.
    function automatic logic is_div(input logic [3:0] op);
        return (op == HILO_OP_DIV) || (op == HILO_OP_DIVU);
    endfunction

    // Everything except the explicitly unsigned ops treats operands as signed.
    function automatic logic is_signed(input logic [3:0] op);
        return (op != HILO_OP_MULTU) && (op != HILO_OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide on operand
// magnitudes, with the sign fix-up applied to the post-step value.
module hilo_iter_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_b_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic               is_div_q;
    logic               neg_main_q;   // negate product / quotient
    logic               neg_rem_q;    // remainder follows dividend sign
    logic               div_zero_q;

    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_top, div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    assign sgn   = is_signed(op_i);
    assign mag_a = (sgn && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    assign mag_b = (sgn && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

    // One shift-add (multiply) or shift-subtract (divide) step on the accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        div_top  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, mag_b_q};
        acc_d    = acc_q;
        if (is_div_q) begin
            if (div_diff[WIDTH])
                acc_d = {div_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            else
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Latch operand magnitudes and sign info on accept, then step each run cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q      <= '0;
            mag_b_q    <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (load_i) begin
            acc_q      <= {{WIDTH{1'b0}}, mag_a};
            mag_b_q    <= mag_b;
            a_raw_q    <= a_i;
            is_div_q   <= is_div(op_i);
            neg_main_q <= sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_rem_q  <= sgn && a_i[WIDTH-1];
            div_zero_q <= (b_i == '0);
        end else if (step_i) begin
            acc_q <= acc_d;
        end
    end

    // Sign fix-up on the value the current step produces, so the final step's
    // result is available at the completion edge.
    always_comb begin
        prod = neg_main_q ? (~acc_d + 1'b1) : acc_d;
        quot = acc_d[WIDTH-1:0];
        rem  = acc_d[2*WIDTH-1:WIDTH];
        hi_o = prod[2*WIDTH-1:WIDTH];
        lo_o = prod[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                lo_o = '1;
                hi_o = a_raw_q;
            end else begin
                lo_o = neg_main_q ? (~quot + 1'b1) : quot;
                hi_o = neg_rem_q  ? (~rem + 1'b1)  : rem;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Handshake: a request is taken on a rising edge where Start=1, Busy=0 and
// Cancel=0; Start seen while Busy=1 is dropped, so the requester holds it.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [3:0]         op_q;

    logic               accept_iter;
    logic               core_step;
    logic [WIDTH-1:0]   core_hi, core_lo;
    logic [2*WIDTH-1:0] hilo_cur, core_res, hilo_new;

    assign accept_iter = (state_q == S_IDLE) && Start && !Cancel && (is_mul(Op) || is_div(Op));
    assign core_step   = (state_q == S_RUN) && !Cancel;

    hilo_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .load_i  (accept_iter),
        .step_i  (core_step),
        .op_i    (Op),
        .a_i     (A),
        .b_i     (B),
        .hi_o    (core_hi),
        .lo_o    (core_lo)
    );

    // Accumulate ops merge the product into the HI/LO value held since accept.
    always_comb begin
        hilo_cur = {hi_q, lo_q};
        core_res = {core_hi, core_lo};
        case (op_q)
            HILO_OP_MADD: hilo_new = hilo_cur + core_res;
            HILO_OP_MSUB: hilo_new = hilo_cur - core_res;
            default:      hilo_new = core_res;
        endcase
    end

    // Control FSM with Reset > Cancel > Start priority; owns HI/LO writes.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= HILO_OP_MULT;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start && !Cancel) begin
                        if (Op == HILO_OP_MTHI) begin
                            hi_q <= A;
                        end else if (Op == HILO_OP_MTLO) begin
                            lo_q <= A;
                        end else if (is_mul(Op) || is_div(Op)) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            cnt_q   <= CW'(ITER - 1);
                            op_q    <= Op;
                        end
                    end
                end
                S_RUN: begin
                    if (Cancel) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        hi_q    <= hilo_new[2*WIDTH-1:WIDTH];
                        lo_q    <= hilo_new[WIDTH-1:0];
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
